cpcs_tx_align_seq: RTL
======================

Name: cpcs_tx_align_seq

Overview:
- Transmit-side link sequencer that sits in front of the 8b10b encoder in the EPCS Tx clock domain.
- Sends the comma burst the far-end word aligner needs to lock, then passes user words through, inserting idle words when no user word is available.
- Optionally re-sends the comma burst at a fixed period so a far end that has lost alignment can re-lock.
- Counts encoder INVALID_K reports.

Parameters:
- EPCS_DWIDTH, 20, SerDes width: 10, 20, 40 or 80.
- ENDEC_DWIDTH, (EPCS_DWIDTH/10)*8, unencoded data width.
- IO_SIZE, (EPCS_DWIDTH/10)-1, index of the highest byte lane.
- NO_OF_COMMAS, 10, number of commas the far-end aligner requires (1..2048).
- ALIGN_MARGIN, 4, extra burst words sent beyond NO_OF_COMMAS (0..255).
- COMMA_DETECT_SEL, 0, comma selection: 0 = K28.5 (0xBC), 1 = K28.1 (0x3C), 3 = K28.7 (0xFC); 2 is treated as 0.
- REALIGN_PERIOD, 0, number of DATA-state cycles between comma bursts; 0 disables periodic re-bursts (0..2^20-1).

Ports:
- CLK  in  1  EPCS Tx clock.
- RST_N  in  1  reset, synchronous, active-low.
- EPCS_READY  in  1  SerDes lane ready.
- LINK_EN  in  1  enables link bring-up.
- USR_DATA  in  ENDEC_DWIDTH  user word; lane n is bits [8n+7:8n].
- USR_K  in  IO_SIZE+1  per-lane K flags for the user word.
- USR_VALID  in  1  user word available.
- USR_READY  out  1  sequencer accepts a user word this cycle.
- TX_DATA  out  ENDEC_DWIDTH  to the encoder data input.
- TX_K_CHAR  out  IO_SIZE+1  to the encoder K input.
- INVALID_K  in  IO_SIZE+1  from the encoder.
- CNT_CLR  in  1  clears KERR_CNT.
- LINK_UP  out  1  high while in the DATA state.
- KERR_CNT  out  8  saturating count of INVALID_K events.

Behaviour:
- All state is updated on the rising edge of CLK. RST_N low at an edge forces:
  - state = IDLE
  - TX_DATA = 0, TX_K_CHAR = 0
  - LINK_UP = 0, KERR_CNT = 0
  - burst counter and period counter = 0
- Word definitions:
  - Comma word: lane 0 = selected comma with K=1; other lanes = D21.5 (0xB5) with K=0.
  - Idle word: identical to the comma word.
- States:
  - IDLE: TX_DATA = 0, TX_K_CHAR = 0.
  - ALIGN: sends comma words.
  - DATA: passes user words or sends idle words.
- Transitions, in priority order: reset, then drop, then the normal transition.
  - Drop: EPCS_READY = 0 or LINK_EN = 0 in any state gives IDLE at the next edge.
  - IDLE to ALIGN when EPCS_READY & LINK_EN; the burst counter is cleared.
  - ALIGN sends exactly NO_OF_COMMAS+ALIGN_MARGIN comma words, then moves to DATA; the period counter is cleared.
  - DATA to ALIGN when REALIGN_PERIOD != 0 and the period counter = REALIGN_PERIOD-1.
- Period counter: increments on every DATA-state cycle and is held while not in DATA.
- USR_READY (combinational) = (state == DATA) & EPCS_READY & LINK_EN & NOT(REALIGN_PERIOD != 0 and period counter = REALIGN_PERIOD-1).
  - It is low on the last DATA cycle before a re-burst, so no accepted word is lost.
- Handshake:
  - A word is accepted when USR_VALID & USR_READY at an edge.
  - The accepted word appears on TX_DATA/TX_K_CHAR registered at that edge, i.e. 1 cycle of latency.
  - In a DATA cycle with no acceptance, the registered output is the idle word.
- TX_DATA/TX_K_CHAR track state one cycle late:
  - First comma word is registered on the IDLE to ALIGN edge.
  - Last comma word is registered on the ALIGN to DATA edge.
- LINK_UP is registered and equals 1 when the next state is DATA.
- KERR_CNT:
  - +1 at each edge where |INVALID_K = 1.
  - Saturates at 255.
  - CNT_CLR takes priority over a simultaneous increment (result 0).
- A drop or reset in the middle of a burst abandons it. The next bring-up sends a full burst.
- The user K flags are passed through unmodified. User commas are legal in DATA.

Test Plan:
- Bring-up (EPCS_DWIDTH=20, NO_OF_COMMAS=10, ALIGN_MARGIN=4, COMMA_DETECT_SEL=0): release RST_N with EPCS_READY=LINK_EN=1 -> exactly 14 cycles of TX_DATA=16'hB5BC, TX_K_CHAR=2'b01; then LINK_UP=1; USR_READY=0 throughout the burst.
- Data path: in DATA, drive USR_DATA=16'h1234, USR_K=2'b00, USR_VALID=1 for one cycle -> next cycle TX_DATA=16'h1234, TX_K_CHAR=0; following cycle (USR_VALID=0) shows the idle word 16'hB5BC / 2'b01.
- Periodic realign with REALIGN_PERIOD=8 and USR_VALID held high: USR_READY is high for 7 cycles, low on the 8th; then a 14-word burst; no user word is duplicated or dropped (scoreboard check).
- Drop mid-burst: deassert EPCS_READY after 5 comma words -> IDLE next edge with TX_DATA=0; reassert -> a full 14-word burst.
- Counter: pulse INVALID_K=2'b10 for 300 cycles -> KERR_CNT=255; assert CNT_CLR together with INVALID_K -> 0.
- Comma select COMMA_DETECT_SEL=1 with EPCS_DWIDTH=10 -> burst words TX_DATA=8'h3C, TX_K_CHAR=1'b1.

Source files
------------

// File: rtl/cpcs_tx_align_seq.sv
// rtl/cpcs_tx_align_seq.sv - EPCS Tx link sequencer: comma burst, user pass-through, idle insertion
// Optional periodic re-burst and saturating INVALID_K counter.
module cpcs_tx_align_seq #(
  parameter int EPCS_DWIDTH      = 20,
  parameter int ENDEC_DWIDTH     = (EPCS_DWIDTH/10)*8,
  parameter int IO_SIZE          = (EPCS_DWIDTH/10)-1,
  parameter int NO_OF_COMMAS     = 10,
  parameter int ALIGN_MARGIN     = 4,
  parameter int COMMA_DETECT_SEL = 0,
  parameter int REALIGN_PERIOD   = 0
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    EPCS_READY,
  input  logic                    LINK_EN,
  input  logic [ENDEC_DWIDTH-1:0] USR_DATA,
  input  logic [IO_SIZE:0]        USR_K,
  input  logic                    USR_VALID,
  output logic                    USR_READY,
  output logic [ENDEC_DWIDTH-1:0] TX_DATA,
  output logic [IO_SIZE:0]        TX_K_CHAR,
  input  logic [IO_SIZE:0]        INVALID_K,
  input  logic                    CNT_CLR,
  output logic                    LINK_UP,
  output logic [7:0]              KERR_CNT
);

  typedef enum logic [1:0] {ST_IDLE, ST_ALIGN, ST_DATA} state_e;

  localparam int         BURST_LEN   = NO_OF_COMMAS + ALIGN_MARGIN;
  // The first comma leaves on the IDLE->ALIGN edge, so ALIGN itself lasts BURST_LEN-1 cycles.
  localparam logic [11:0] BURST_LAST  = 12'((BURST_LEN >= 2) ? BURST_LEN - 2 : 0);
  localparam logic [19:0] PERIOD_LAST = 20'((REALIGN_PERIOD > 0) ? REALIGN_PERIOD - 1 : 0);
  localparam logic [7:0]  COMMA_CHAR  = (COMMA_DETECT_SEL == 1) ? 8'h3C :
                                        (COMMA_DETECT_SEL == 3) ? 8'hFC : 8'hBC;
  localparam logic [7:0]  D21_5       = 8'hB5;

  state_e                  state_q, state_d;
  logic [11:0]             burst_cnt_q, burst_cnt_d;
  logic [19:0]             period_cnt_q, period_cnt_d;
  logic [ENDEC_DWIDTH-1:0] tx_data_q, tx_data_d, comma_data;
  logic [IO_SIZE:0]        tx_k_q, tx_k_d, comma_k;
  logic                    link_up_q;
  logic [7:0]              kerr_q, kerr_d;
  logic                    lane_ok, realign_hit, accept;

  always_comb begin
    comma_data = '0;
    for (int n = 0; n <= IO_SIZE; n++) begin
      comma_data[8*n +: 8] = (n == 0) ? COMMA_CHAR : D21_5;
    end
    comma_k    = '0;
    comma_k[0] = 1'b1;
  end

  assign lane_ok     = EPCS_READY & LINK_EN;
  assign realign_hit = (REALIGN_PERIOD != 0) && (period_cnt_q == PERIOD_LAST);
  assign USR_READY   = (state_q == ST_DATA) & lane_ok & ~realign_hit;
  assign accept      = USR_READY & USR_VALID;

  always_comb begin
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    period_cnt_d = period_cnt_q;
    if (state_q == ST_DATA) begin
      period_cnt_d = period_cnt_q + 20'd1;
    end
    if (!lane_ok) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d     = ST_ALIGN;
          burst_cnt_d = '0;
        end
        ST_ALIGN: begin
          if (burst_cnt_q >= BURST_LAST) begin
            state_d      = ST_DATA;
            period_cnt_d = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + 12'd1;
          end
        end
        ST_DATA: begin
          if (realign_hit) begin
            state_d     = ST_ALIGN;
            burst_cnt_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Output word follows the next state: zero in IDLE, user word on acceptance, else comma/idle.
    if (state_d == ST_IDLE) begin
      tx_data_d = '0;
      tx_k_d    = '0;
    end else if (accept) begin
      tx_data_d = USR_DATA;
      tx_k_d    = USR_K;
    end else begin
      tx_data_d = comma_data;
      tx_k_d    = comma_k;
    end

    kerr_d = kerr_q;
    if (CNT_CLR) begin
      kerr_d = '0;
    end else if ((|INVALID_K) && (kerr_q != 8'hFF)) begin
      kerr_d = kerr_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      burst_cnt_q  <= '0;
      period_cnt_q <= '0;
      tx_data_q    <= '0;
      tx_k_q       <= '0;
      link_up_q    <= 1'b0;
      kerr_q       <= '0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      period_cnt_q <= period_cnt_d;
      tx_data_q    <= tx_data_d;
      tx_k_q       <= tx_k_d;
      link_up_q    <= (state_d == ST_DATA);
      kerr_q       <= kerr_d;
    end
  end

  assign TX_DATA   = tx_data_q;
  assign TX_K_CHAR = tx_k_q;
  assign LINK_UP   = link_up_q;
  assign KERR_CNT  = kerr_q;

endmodule
